// File: rtl/clk_div_bank.sv
// Bank of independent, runtime-programmable clock dividers.
// Each channel emits a divided clk_out waveform (high for ceil(N/2) cycles,
// low for the rest) and a one-cycle tick on every rising edge of clk_out.
// A new divisor is held as pending and only applied at a period boundary,
// so a running waveform never produces a runt pulse. Disabling a channel
// lets the current period finish. A one-cycle sync pulse restarts every
// enabled channel in phase.
//
// Timing of the inputs:
// - ch_en and sync are sampled at clock edge k.
// - The resulting boundary happens at edge k+1.
// - At a boundary, clk_out and tick go high in the cycle after the edge.
// - The registered copies en_q and sync_q hold "what was sampled at edge k".
//
// Handshake: there is none. cfg_we is a plain strobe that is accepted
// unconditionally on every edge it is high. Writes addressed to
// channel >= N_CH are dropped.
module clk_div_bank #(
  parameter int N_CH    = 2,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 100,
  parameter int CH_W    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      ch_en,
  input  logic                 sync,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_W-1:0]     cfg_div,
  output logic [N_CH-1:0]      clk_out,
  output logic [N_CH-1:0]      tick,
  output logic [N_CH-1:0]      pending,
  output logic [N_CH-1:0]      running,
  output logic [2*N_CH-1:0]    state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);

  // Per-channel registered state.
  logic [1:0]       state_q [N_CH];
  logic [DIV_W-1:0] cnt_q   [N_CH];
  logic [DIV_W-1:0] div_q   [N_CH];
  logic [DIV_W-1:0] pdiv_q  [N_CH];
  logic [N_CH-1:0]  en_q;
  logic             sync_q;

  // Next-state values.
  logic [1:0]       state_d [N_CH];
  logic [DIV_W-1:0] cnt_d   [N_CH];
  logic [DIV_W-1:0] div_d   [N_CH];
  logic [DIV_W-1:0] pdiv_d  [N_CH];
  logic [N_CH-1:0]  clk_d;
  logic [N_CH-1:0]  tick_d;
  logic [N_CH-1:0]  pend_d;
  logic [N_CH-1:0]  run_d;

  // Divisors below 2 cannot form a high and a low phase, so clamp them.
  logic [DIV_W-1:0] wr_div;
  assign wr_div = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;

  // Expose every channel's FSM state as a flat debug vector.
  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_dbg[2*i +: 2] = state_q[i];
    end
  end

  // Per-channel next state.
  // A boundary is taken in three cases:
  // - an idle channel was enabled at the previous edge;
  // - sync and enable were both sampled at the previous edge;
  // - the low phase ends while the channel is still enabled.
  always_comb begin
    logic             wr_hit;
    logic             last;
    logic             bnd;
    logic [DIV_W:0]   cnt_inc;
    logic [DIV_W:0]   half;
    wr_hit  = 1'b0;
    last    = 1'b0;
    bnd     = 1'b0;
    cnt_inc = '0;
    half    = '0;
    clk_d   = '0;
    tick_d  = '0;
    pend_d  = pending;
    run_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      pdiv_d[i]  = pdiv_q[i];

      wr_hit  = cfg_we && (int'(cfg_ch) == i);
      last    = (state_q[i] == ST_LOW) && (cnt_q[i] == div_q[i] - DIV_W'(1));
      bnd     = (en_q[i] && ((state_q[i] == ST_IDLE) || sync_q)) ||
                (last && ch_en[i]);
      cnt_inc = {1'b0, cnt_q[i]} + (DIV_W+1)'(1);
      half    = ({1'b0, div_q[i]} + (DIV_W+1)'(1)) >> 1;

      if (bnd) begin
        // The pending value applied here was written at an earlier edge.
        // A write on this very edge is queued for the following period.
        if (pending[i]) begin
          div_d[i] = pdiv_q[i];
        end
        state_d[i] = ST_HIGH;
        cnt_d[i]   = '0;
        pend_d[i]  = wr_hit;
        if (wr_hit) begin
          pdiv_d[i] = wr_div;
        end
      end else begin
        if (last) begin
          // The enable has gone; finish quietly, without a tick.
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end else if (state_q[i] != ST_IDLE) begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
          if ((state_q[i] == ST_HIGH) && (cnt_inc == half)) begin
            state_d[i] = ST_LOW;
          end
        end
        if (wr_hit) begin
          pend_d[i] = 1'b1;
          pdiv_d[i] = wr_div;
        end
      end

      tick_d[i] = bnd;
      clk_d[i]  = (state_d[i] == ST_HIGH);
      run_d[i]  = (state_d[i] != ST_IDLE);
    end
  end

  // State and output registers. Reset aborts any period in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        div_q[i]   <= DEF_DIV_V;
        pdiv_q[i]  <= DEF_DIV_V;
      end
      en_q    <= '0;
      sync_q  <= 1'b0;
      clk_out <= '0;
      tick    <= '0;
      pending <= '0;
      running <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        pdiv_q[i]  <= pdiv_d[i];
      end
      en_q    <= ch_en;
      sync_q  <= sync;
      clk_out <= clk_d;
      tick    <= tick_d;
      pending <= pend_d;
      running <= run_d;
    end
  end

endmodule
